// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: walks the PC through memory reads and hands words to the decoder.
// Optional WAIT watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic              soft_clr,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              pc_inc,
    output logic              pc_load,
    output logic              pc_clear,
    output logic [ADDR_W-1:0] pc_load_val,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jmp_req,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic              busy,
    output logic              fetch_err
);
    // state | meaning
    // IDLE  | after reset, waiting for start
    // ADDR  | read strobe out, mem_addr holds the PC
    // WAIT  | waiting for mem_rd_valid
    // HOLD  | instr_valid high until instr_ready
    // HALT  | stopped by halt_req or watchdog, waiting for start
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] next_pc;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("fetch_sequencer: TIMEOUT_CYC must be at least 1");
    end

    // PC controls land one edge after they are issued, so the read address forwards them
    always_comb begin
        next_pc = pc_value;
        if (pc_clear)
            next_pc = '0;
        else if (pc_load)
            next_pc = pc_load_val;
        else if (pc_inc)
            next_pc = pc_value + ADDR_W'(1);
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc_inc      <= 1'b0;
            pc_load     <= 1'b0;
            pc_clear    <= 1'b0;
            pc_load_val <= '0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            to_cnt      <= '0;
            fetch_err   <= 1'b0;
`endif
        end else begin
            pc_inc    <= 1'b0;
            pc_load   <= 1'b0;
            pc_clear  <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state     <= S_ADDR;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= next_pc;
                        busy      <= 1'b1;
                    end else if (soft_clr) begin
                        pc_clear <= 1'b1;
                    end
                end
                S_ADDR: begin
                    state <= S_WAIT;
`ifdef FETCH_TIMEOUT_EN
                    to_cnt <= TO_W'(TIMEOUT_CYC - 1);
`endif
                end
                S_WAIT: begin
                    if (mem_rd_valid) begin
                        state       <= S_HOLD;
                        instr       <= mem_rdata;
                        instr_valid <= 1'b1;
                        pc_inc      <= 1'b1;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (to_cnt == '0) begin
                        state     <= S_HALT;
                        busy      <= 1'b0;
                        fetch_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt - TO_W'(1);
                    end
`endif
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        if (jmp_req) begin
                            pc_load     <= 1'b1;
                            pc_load_val <= jmp_addr;
                        end
                        if (halt_req) begin
                            state <= S_HALT;
                            busy  <= 1'b0;
                        end else begin
                            state     <= S_ADDR;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= jmp_req ? jmp_addr : next_pc;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios then random traffic, all checked against
// a fetch-level reference model (address stream, handshake, PC pulses).
module tb_fetch_sequencer;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset, start, halt_req, soft_clr;
    logic [AW-1:0] pc;
    logic          pc_inc, pc_load, pc_clear;
    logic [AW-1:0] pc_load_val, mem_addr, jmp_addr;
    logic          mem_rd_en, mem_rd_valid, instr_valid, instr_ready, jmp_req, busy, fetch_err;
    logic [DW-1:0] mem_rdata, instr;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .soft_clr(soft_clr),
        .pc_value(pc), .pc_inc(pc_inc), .pc_load(pc_load), .pc_clear(pc_clear),
        .pc_load_val(pc_load_val), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .jmp_req(jmp_req),
        .jmp_addr(jmp_addr), .busy(busy), .fetch_err(fetch_err)
    );

    int checks = 0;
    int errors = 0;

    // reference model: running / read due / data outstanding / word on offer
    logic          m_running, m_rd, m_awaiting, m_holding, m_inc, m_load, m_clr, m_err;
    logic [AW-1:0] m_next_addr, m_load_val;
    logic [DW-1:0] m_instr;
    int            m_wait_cnt;

    // snapshot of DUT outputs at the last falling edge
    logic          s_rd, s_inc, s_load, s_clr, s_valid, s_busy, s_err;
    logic [AW-1:0] s_addr, s_load_val;
    logic [DW-1:0] s_instr;

    // memory / environment
    int            mem_lat, mem_cnt, inc_count, inc_saved;
    logic          mem_silent, mem_fixed_en, spurious_en;
    logic [DW-1:0] mem_fixed, mem_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_running = 0; m_rd = 0; m_awaiting = 0; m_holding = 0;
        m_inc = 0; m_load = 0; m_clr = 0; m_err = 0;
        m_instr = '0; m_load_val = '0; m_wait_cnt = 0;
    endtask

    task automatic cycle();
        logic cur_rd;
        @(negedge clk);
        if (reset) model_clear();
        s_rd = mem_rd_en; s_addr = mem_addr; s_inc = pc_inc; s_load = pc_load; s_clr = pc_clear;
        s_load_val = pc_load_val; s_valid = instr_valid; s_instr = instr; s_busy = busy; s_err = fetch_err;
        check("busy", busy, m_running);
        check("instr_valid", instr_valid, m_holding);
        check("instr", instr, m_instr);
        check("mem_rd_en", mem_rd_en, m_rd);
        if (m_rd) check("mem_addr", mem_addr, m_next_addr);
        check("pc_inc", pc_inc, m_inc);
        check("pc_load", pc_load, m_load);
        if (m_load) check("pc_load_val", pc_load_val, m_load_val);
        check("pc_clear", pc_clear, m_clr);
        check("pc_onehot", 32'($countones({pc_inc, pc_load, pc_clear}) <= 1), 1);
        check("fetch_err", fetch_err, m_err);

        cur_rd = m_rd;
        m_rd = 0; m_inc = 0; m_load = 0; m_clr = 0;
        if (!reset) begin
            if (!m_running) begin
                if (start) begin
                    m_running = 1; m_rd = 1;
                end else if (soft_clr) begin
                    m_clr = 1; m_next_addr = '0;
                end
            end else if (cur_rd) begin
                m_awaiting = 1; m_wait_cnt = 0;
            end else if (m_awaiting) begin
                if (mem_rd_valid) begin
                    m_awaiting = 0; m_holding = 1; m_instr = mem_rdata; m_inc = 1;
                    m_next_addr = m_next_addr + 16'd1;
                end else begin
                    m_wait_cnt++;
`ifdef FETCH_TIMEOUT_EN
                    if (m_wait_cnt == TO) begin
                        m_awaiting = 0; m_running = 0; m_err = 1;
                    end
`endif
                end
            end else if (m_holding && instr_ready) begin
                m_holding = 0;
                if (jmp_req) begin
                    m_load = 1; m_load_val = jmp_addr; m_next_addr = jmp_addr;
                end
                if (halt_req) m_running = 0;
                else m_rd = 1;
            end
        end

        @(posedge clk);
        #1;
        if (s_clr) pc = '0;
        else if (s_load) pc = s_load_val;
        else if (s_inc) pc = pc + 16'd1;
        if (s_inc) inc_count++;
        mem_rd_valid = 1'b0;
        if (s_rd && !mem_silent) begin
            mem_cnt = mem_lat;
            mem_data = mem_fixed_en ? mem_fixed : DW'($urandom);
        end
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                mem_rd_valid = 1'b1; mem_rdata = mem_data;
            end
        end else if (spurious_en && !m_awaiting && $urandom_range(0, 4) == 0) begin
            mem_rd_valid = 1'b1; mem_rdata = DW'($urandom);
        end
    endtask

    initial begin
        reset = 1; start = 0; halt_req = 0; soft_clr = 0; mem_rd_valid = 0; mem_rdata = '0;
        instr_ready = 0; jmp_req = 0; jmp_addr = '0; pc = 16'h0010;
        mem_lat = 1; mem_cnt = 0; mem_silent = 0; mem_fixed_en = 1; mem_fixed = 16'hA5A5;
        spurious_en = 0; inc_count = 0; inc_saved = 0;
        model_clear();
        m_next_addr = 16'h0010;

        // reset state
        repeat (2) cycle();
        check("rst_mem_addr", s_addr, 0);
        check("rst_load_val", s_load_val, 0);
        check("rst_instr", s_instr, 0);
        reset = 0;
        cycle();

        // first fetch from 0x0010, memory answers next cycle
        start = 1; cycle(); start = 0;
        cycle();
        check("first_rd_en", s_rd, 1);
        check("first_addr", s_addr, 16'h0010);
        cycle();
        check("valid_before_3rd_edge", s_valid, 0);
        cycle();
        check("valid_at_3rd_edge", s_valid, 1);
        check("first_instr", s_instr, 16'hA5A5);
        check("first_inc", s_inc, 1);

        // decoder stalls for 5 cycles
        repeat (5) begin
            cycle();
            check("stall_valid", s_valid, 1);
            check("stall_instr", s_instr, 16'hA5A5);
            check("stall_pulses", {s_inc, s_load, s_clr}, 0);
        end
        check("single_inc", inc_count, 1);

        // handshake with jump
        mem_fixed = 16'h5A5A;
        instr_ready = 1; jmp_req = 1; jmp_addr = 16'h1234;
        cycle();
        instr_ready = 0; jmp_req = 0;
        cycle();
        check("jmp_load", s_load, 1);
        check("jmp_load_val", s_load_val, 16'h1234);
        check("jmp_no_inc", s_inc, 0);
        check("jmp_addr_out", s_addr, 16'h1234);
        repeat (2) cycle();
        check("jmp_instr", s_instr, 16'h5A5A);
        cycle();
        check("pc_after_jmp", pc, 16'h1235);

        // halt at handshake, soft clear in HALT, restart
        instr_ready = 1; halt_req = 1; cycle();
        instr_ready = 0; halt_req = 0; cycle();
        check("halted_busy", s_busy, 0);
        soft_clr = 1; cycle(); soft_clr = 0;
        cycle();
        check("clr_pulse", s_clr, 1);
        cycle();
        check("clr_one_cycle", s_clr, 0);
        check("pc_cleared", pc, 0);
        start = 1; cycle(); start = 0;
        mem_lat = 3;
        cycle();
        check("resume_rd", s_rd, 1);
        check("resume_addr", s_addr, 0);

        // reset while waiting, response arrives afterwards
        cycle();
        inc_saved = inc_count;
        reset = 1; cycle(); reset = 0;
        repeat (4) cycle();
        check("rstwait_busy", s_busy, 0);
        check("rstwait_instr", s_instr, 0);
        check("rstwait_no_inc", inc_count, inc_saved);

        // silent memory
        mem_silent = 1; start = 1; cycle(); start = 0;
        repeat (8) cycle();
`ifdef FETCH_TIMEOUT_EN
        check("to_busy", s_busy, 0);
        check("to_err", s_err, 1);
        check("to_no_inc", inc_count, inc_saved);
        cycle();
        check("to_err_sticky", s_err, 1);
`else
        check("nto_busy", s_busy, 1);
        check("nto_valid", s_valid, 0);
`endif
        reset = 1; cycle(); reset = 0;
        check("err_after_reset", s_err, 0);
        mem_silent = 0; mem_cnt = 0;
        cycle();

        // PC wrap
        pc = 16'hFFFF; m_next_addr = 16'hFFFF; mem_lat = 1;
        start = 1; cycle(); start = 0;
        cycle();
        check("wrap_addr_hi", s_addr, 16'hFFFF);
        repeat (2) cycle();
        instr_ready = 1; cycle(); instr_ready = 0;
        cycle();
        check("wrap_rd", s_rd, 1);
        check("wrap_addr_lo", s_addr, 0);

        // random traffic
        mem_fixed_en = 0; spurious_en = 1;
        for (int i = 0; i < 800; i++) begin
            start       = ($urandom_range(0, 2) == 0);
            soft_clr    = ($urandom_range(0, 3) == 0);
            halt_req    = ($urandom_range(0, 7) == 0);
            jmp_req     = ($urandom_range(0, 3) == 0);
            jmp_addr    = ($urandom_range(0, 7) == 0) ? 16'hFFFF : AW'($urandom);
            instr_ready = ($urandom_range(0, 2) != 0);
            mem_lat     = $urandom_range(1, 3);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
